// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MIPS memory-access stage:
// dump FSM states, access-size encoding, lane masks and load extension.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } access_size_t;

  localparam int NB_LANE   = 8;
  localparam int NUM_LANES = 4;

  function automatic access_size_t size_sel(input logic byte_en, input logic half_en,
                                            input logic word_en);
    access_size_t sz;
    if (word_en) begin
      sz = SZ_WORD;
    end else if (half_en) begin
      sz = SZ_HALF;
    end else if (byte_en) begin
      sz = SZ_BYTE;
    end else begin
      sz = SZ_NONE;
    end
    return sz;
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_mask(input access_size_t sz, input logic [1:0] lane);
    logic [NUM_LANES-1:0] m;
    case (sz)
      SZ_WORD: m = 4'b1111;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: m = 4'b0001 << lane;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the store operand so every lane sees the bytes it may receive.
  function automatic logic [31:0] store_align(input access_size_t sz, input logic [31:0] data);
    logic [31:0] d;
    case (sz)
      SZ_WORD: d = data;
      SZ_HALF: d = {2{data[15:0]}};
      SZ_BYTE: d = {4{data[7:0]}};
      default: d = data;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extend_load(input access_size_t sz, input logic [1:0] lane,
                                              input logic sgn, input logic [31:0] word);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    case (sz)
      SZ_WORD: r = word;
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Byte-lane-writable data RAM: one synchronous write port and two
// asynchronous read ports (pipeline load and memory dump).
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic                 clock,
  input  logic [NUM_LANES-1:0] we_mask,
  input  logic [NB_ADDR-1:0]   wr_addr,
  input  logic [NB_DATA-1:0]   wr_data,
  input  logic [NB_ADDR-1:0]   rd_addr,
  output logic [NB_DATA-1:0]   rd_data,
  input  logic [NB_ADDR-1:0]   dump_addr,
  output logic [NB_DATA-1:0]   dump_data
);

  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem_r [DEPTH];

  // Per-lane write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (we_mask[l]) begin
        mem_r[wr_addr][NB_LANE*l +: NB_LANE] <= wr_data[NB_LANE*l +: NB_LANE];
      end
    end
  end

  assign rd_data   = mem_r[rd_addr];
  assign dump_data = mem_r[dump_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory access with load extension, branch resolution
// and a valid/ready memory-dump sequencer for the debug unit.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_PC   = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               MEM_mem_read,
  input  logic               MEM_mem_write,
  input  logic               MEM_byte_en,
  input  logic               MEM_halfword_en,
  input  logic               MEM_word_en,
  input  logic               MEM_signed,
  input  logic [NB_PC-1:0]   MEM_alu_result,
  input  logic [NB_PC-1:0]   MEM_data_a,
  input  logic               MEM_branch,
  input  logic               MEM_zero,
  output logic [NB_PC-1:0]   o_read_data,
  output logic               o_pc_src,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_PC-1:0]   o_dump_data,
  output logic               o_dump_done
);

  localparam logic [NB_ADDR-1:0] LAST_IDX = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] ONE_IDX  = {{(NB_ADDR-1){1'b0}}, 1'b1};

  access_size_t         size_s;
  logic [NB_ADDR-1:0]   word_idx_s;
  logic [1:0]           lane_s;
  logic [NUM_LANES-1:0] we_mask_s;
  logic [NB_PC-1:0]     rd_word_s;
  logic                 unused_addr_s;

  dump_state_t          state_r, state_nxt_s;
  logic [NB_ADDR-1:0]   cnt_r, cnt_nxt_s;
  logic                 valid_r, done_r;

  assign size_s        = size_sel(MEM_byte_en, MEM_halfword_en, MEM_word_en);
  assign word_idx_s    = MEM_alu_result[NB_ADDR+1:2];
  assign lane_s        = MEM_alu_result[1:0];
  assign we_mask_s     = MEM_mem_write ? lane_mask(size_s, lane_s) : 4'b0000;
  // Upper address bits wrap away by design.
  assign unused_addr_s = ^MEM_alu_result[NB_PC-1:NB_ADDR+2];

  data_memory #(
    .NB_DATA (NB_PC),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .clock     (i_clock),
    .we_mask   (we_mask_s),
    .wr_addr   (word_idx_s),
    .wr_data   (store_align(size_s, MEM_data_a)),
    .rd_addr   (word_idx_s),
    .rd_data   (rd_word_s),
    .dump_addr (cnt_r),
    .dump_data (o_dump_data)
  );

  assign o_read_data = MEM_mem_read ? extend_load(size_s, lane_s, MEM_signed, rd_word_s)
                                    : {NB_PC{1'b0}};
  assign o_pc_src    = MEM_branch & MEM_zero;

  // Dump sequencer next state and word counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_nxt_s = ST_DUMP;
          cnt_nxt_s   = {NB_ADDR{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DUMP: begin
        if (i_dump_ready && (cnt_r == LAST_IDX)) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = {NB_ADDR{1'b0}};
        end else if (i_dump_ready) begin
          cnt_nxt_s   = cnt_r + ONE_IDX;
        end else begin
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {NB_ADDR{1'b0}};
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {NB_ADDR{1'b0}};
      end
    endcase
  end

  // Dump state, counter and registered handshake outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {NB_ADDR{1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= (state_nxt_s == ST_DUMP);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign o_dump_valid = valid_r;
  assign o_dump_done  = done_r;
  assign o_dump_addr  = cnt_r;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, fed directly by the EX/MEM pipeline register and feeding the MEM/WB register. It holds the data memory, performs byte/halfword/word stores and sign- or zero-extended loads, and resolves the branch-taken signal. It also contains a memory-dump sequencer that streams every data-memory word to the debug unit over a valid/ready handshake.

## Interface
Parameters:
- NB_PC, 32, data/address width.
- NB_ADDR, 5, word-address bits; memory depth is 2^NB_ADDR words.

Ports:
- i_clock, in, 1, the block's single clock; memory writes and FSM update on the rising edge.
- i_reset, in, 1, asynchronous, active-high reset.
- MEM_mem_read, in, 1, load enable.
- MEM_mem_write, in, 1, store enable.
- MEM_byte_en, in, 1, access size is byte.
- MEM_halfword_en, in, 1, access size is halfword.
- MEM_word_en, in, 1, access size is word.
- MEM_signed, in, 1, 1 = sign-extend loads, 0 = zero-extend loads.
- MEM_alu_result, in, NB_PC, byte address.
- MEM_data_a, in, NB_PC, store data.
- MEM_branch, in, 1, instruction is a branch.
- MEM_zero, in, 1, ALU zero flag.
- o_read_data, out, NB_PC, extended load data.
- o_pc_src, out, 1, branch taken.
- i_dump_start, in, 1, starts a full memory dump.
- i_dump_ready, in, 1, debug unit accepts the current word.
- o_dump_valid, out, 1, dump word is valid.
- o_dump_addr, out, NB_ADDR, word index of the current dump word.
- o_dump_data, out, NB_PC, contents of mem[o_dump_addr].
- o_dump_done, out, 1, one-cycle pulse after the last word is accepted.

## Operation
- Word index = MEM_alu_result[NB_ADDR+1:2]. Byte lane = MEM_alu_result[1:0]. Storage is little-endian.
- Address bits above NB_ADDR+1 are ignored, so addresses wrap modulo memory size.
- Size priority is word > halfword > byte. If mem_write is set with no size enable, no write occurs.
- Halfword accesses ignore addr[0]. Word accesses ignore addr[1:0].
- Store: on the rising edge when MEM_mem_write=1, only the addressed lanes are written.
  - Byte store writes MEM_data_a[7:0] into the lane.
  - Halfword store writes MEM_data_a[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all four lanes.
- Load: asynchronous read.
  - o_read_data is the selected byte or halfword, extended according to MEM_signed. A word load returns the raw word.
  - o_read_data = 0 when MEM_mem_read=0.
- o_pc_src = MEM_branch & MEM_zero, combinational.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: a rising edge with i_dump_start=1 moves to DUMP with the counter at 0.
  - DUMP: o_dump_valid=1. When o_dump_valid & i_dump_ready, the counter increments. At counter = 2^NB_ADDR-1 with a handshake, the FSM goes to DONE.
  - DONE: o_dump_done=1 for one cycle, then IDLE with the counter at 0.
  - i_dump_start is ignored outside IDLE.
- o_dump_addr = counter. o_dump_data = mem[counter], combinational.
- Pipeline stores during a dump are performed. The dump reflects memory contents at the moment each word is presented.

## Timing
- Load data is valid in the same cycle as the address (combinational), ready for the MEM/WB register capture.
- A store takes effect at the rising edge. A load of the same address in the next cycle returns the new data.
- Dump rate is one word per handshake cycle. A full dump with i_dump_ready held high takes 2^NB_ADDR DUMP cycles plus one DONE cycle.
- Reset values:
  - FSM = IDLE, counter = 0.
  - o_dump_valid = 0, o_dump_done = 0, o_dump_addr = 0.
  - o_pc_src and o_read_data follow their inputs.
  - Memory contents are not cleared by reset.
- Reset asserted mid-dump forces IDLE with o_dump_valid = 0 immediately, without waiting for a clock edge.
- Simultaneous store and dump read of the same word: o_dump_data shows the old value until the edge and the new value after it.

## Structure
- Shared package holds:
  - FSM state encodings (IDLE/DUMP/DONE).
  - Size-select constants.
  - Lane-mask and extension helper functions.
- One sub-module, data_memory: byte-lane-writable RAM with one write port, an asynchronous pipeline read port and an asynchronous dump read port.
- The dump FSM, load extension and branch logic live in mem_stage.

## Test plan
- Word store of 0xDEADBEEF at address 0x08, then word load of 0x08 -> o_read_data = 0xDEADBEEF.
- Byte store of 0x80 at 0x0D, then load of 0x0D with MEM_signed=1 -> 0xFFFFFF80; with MEM_signed=0 -> 0x00000080. The other lanes of word 3 are unchanged.
- Halfword store of 0x8001 at 0x12, then load with MEM_signed=1 -> 0xFFFF8001. Bytes 0x10–0x11 are unchanged.
- MEM_branch=1, MEM_zero=1 -> o_pc_src=1. MEM_branch=1, MEM_zero=0 -> o_pc_src=0.
- Dump after preloading mem[k]=k, with i_dump_ready toggling every other cycle:
  - 32 handshakes occur with addr/data 0..31 in order.
  - o_dump_valid is held while i_dump_ready=0.
  - o_dump_done pulses once after the last handshake.
- Dump with i_reset asserted at word 10 -> o_dump_valid=0 asynchronously. After a new start, the dump begins at addr 0.
